// File: rtl/sync_fifo_ext_if.sv
// Handshake/data bundle for sync_fifo_ext: the producer/consumer side drives
// requests, the FIFO drives data and status back.
interface sync_fifo_ext_if #(
   parameter int FIFO_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic                  clr;
   logic [FIFO_WIDTH-1:0] data_in;
   logic                  wr_en;
   logic                  rd_en;
   logic [FIFO_WIDTH-1:0] data_out;
   logic                  empty;
   logic                  full;
   logic                  almost_empty;
   logic                  almost_full;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output clr, data_in, wr_en, rd_en,
      input  data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
   );

   modport slave (
      input  clr, data_in, wr_en, rd_en,
      output data_out, empty, full, almost_empty, almost_full, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with registered status flags, threshold flags, error
// pulses, synchronous flush, and selectable registered-read or FWFT output.
module sync_fifo_ext #(
   parameter int FIFO_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int AF_LEVEL   = FIFO_DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   parameter int FWFT       = 0
) (
   input  logic           clk,
   input  logic           rst,
   sync_fifo_ext_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count, count_nxt;
   logic                  empty_r, full_r, ae_r, af_r, ovf_r, udf_r;
   logic                  wr_acc, rd_acc;

   // Acceptance looks only at registered flags, so a write against FULL is
   // refused even when a read frees a slot on the same edge.
   always_comb begin
      wr_acc    = bus.wr_en && !full_r  && !bus.clr;
      rd_acc    = bus.rd_en && !empty_r && !bus.clr;
      count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= bus.data_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         empty_r <= 1'b1;
         full_r  <= 1'b0;
         ae_r    <= 1'b1;
         af_r    <= 1'b0;
         ovf_r   <= 1'b0;
         udf_r   <= 1'b0;
      end else if (bus.clr) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         empty_r <= 1'b1;
         full_r  <= 1'b0;
         ae_r    <= 1'b1;
         af_r    <= 1'b0;
         ovf_r   <= 1'b0;
         udf_r   <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         count   <= count_nxt;
         empty_r <= (count_nxt == '0);
         full_r  <= (count_nxt == DEPTH_C);
         ae_r    <= (count_nxt <= AE_C);
         af_r    <= (count_nxt >= AF_C);
         ovf_r   <= bus.wr_en && full_r;
         udf_r   <= bus.rd_en && empty_r;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head entry shown combinationally; forced to zero while empty so
         // reset leaves DATA_OUT at 0.
         assign bus.data_out = empty_r ? '0 : mem[rd_ptr];
      end else begin : g_reg
         logic [FIFO_WIDTH-1:0] dout_r;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)        dout_r <= '0;
            else if (rd_acc) dout_r <= mem[rd_ptr];
         end
         assign bus.data_out = dout_r;
      end
   endgenerate

   assign bus.count        = count;
   assign bus.empty        = empty_r;
   assign bus.full         = full_r;
   assign bus.almost_empty = ae_r;
   assign bus.almost_full  = af_r;
   assign bus.overflow     = ovf_r;
   assign bus.underflow    = udf_r;
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Randomized bench for sync_fifo_ext: a registered-read and an FWFT instance
// share stimulus and are checked every cycle against a queue-based model.
module tb_sync_fifo_ext;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [7:0] din = '0;

   int tests = 0, fails = 0;
   bit chk_on = 1'b0;

   // behavioural model
   logic [7:0] q[$];
   logic [7:0] dout0_m = '0;
   bit         ovf_m = 1'b0, udf_m = 1'b0;

   sync_fifo_ext_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(16)) i0 ();
   sync_fifo_ext_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(16)) i1 ();

   assign i0.clr = clr;  assign i0.wr_en = wr;  assign i0.rd_en = rd;  assign i0.data_in = din;
   assign i1.clr = clr;  assign i1.wr_en = wr;  assign i1.rd_en = rd;  assign i1.data_in = din;

   sync_fifo_ext #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .FWFT(0)) dut0 (.clk(clk), .rst(rst), .bus(i0));
   sync_fifo_ext #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      dout0_m = '0;
      ovf_m   = 1'b0;
      udf_m   = 1'b0;
   endtask

   task automatic model_edge();
      bit was_full, was_empty;
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      if (!rst) model_reset();
      else if (clr) begin
         q.delete();
         ovf_m = 1'b0;
         udf_m = 1'b0;
      end else begin
         ovf_m = wr && was_full;
         udf_m = rd && was_empty;
         if (rd && !was_empty) dout0_m = q.pop_front();
         if (wr && !was_full)  q.push_back(din);
      end
   endtask

   // Inputs applied just after an edge; model advanced with what the DUT sampled.
   task automatic step(input bit w, input bit r, input bit c, input logic [7:0] d);
      wr = w; rd = r; clr = c; din = d;
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic fill_to(input int n);
      while (q.size() < n) step(1, 0, 0, 8'($urandom));
      while (q.size() > n) step(0, 1, 0, 8'h00);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("count0", 32'(i0.count), 32'(q.size()));
         chk("empty0", 32'(i0.empty), 32'(q.size() == 0));
         chk("full0",  32'(i0.full),  32'(q.size() == 16));
         chk("ae0",    32'(i0.almost_empty), 32'(q.size() <= 2));
         chk("af0",    32'(i0.almost_full),  32'(q.size() >= 14));
         chk("ovf0",   32'(i0.overflow),  32'(ovf_m));
         chk("udf0",   32'(i0.underflow), 32'(udf_m));
         chk("dout0",  32'(i0.data_out),  32'(dout0_m));
         chk("count1", 32'(i1.count), 32'(q.size()));
         chk("empty1", 32'(i1.empty), 32'(q.size() == 0));
         chk("ovf1",   32'(i1.overflow),  32'(ovf_m));
         chk("udf1",   32'(i1.underflow), 32'(udf_m));
         if (q.size() != 0) chk("dout1", 32'(i1.data_out), 32'(q[0]));
      end
   end

   initial begin
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk("rst_count", 32'(i0.count), 32'd0);
      chk("rst_empty", 32'(i0.empty), 32'd1);
      chk("rst_ae",    32'(i0.almost_empty), 32'd1);
      chk("rst_dout",  32'(i0.data_out), 32'd0);
      chk_on = 1'b1;
      step(0, 0, 0, 8'h00);
      step(0, 0, 0, 8'h00);
      rst = 1'b1;

      // fill 0x01..0x10
      for (int k = 1; k <= 16; k++) begin
         step(1, 0, 0, 8'(k));
         if (k == 13) chk("af_at13", 32'(i0.almost_full), 32'd0);
         if (k == 14) chk("af_at14", 32'(i0.almost_full), 32'd1);
      end
      chk("full16",  32'(i0.full),  32'd1);
      chk("count16", 32'(i0.count), 32'd16);
      step(1, 0, 0, 8'hEE);
      chk("ovf_pulse", 32'(i0.overflow), 32'd1);
      step(0, 0, 0, 8'h00);
      chk("ovf_drop", 32'(i0.overflow), 32'd0);

      // drain
      for (int k = 1; k <= 16; k++) begin
         step(0, 1, 0, 8'h00);
         chk("drain_dout", 32'(i0.data_out), 32'(k));
      end
      chk("drain_empty", 32'(i0.empty), 32'd1);
      step(0, 1, 0, 8'h00);
      chk("udf_pulse", 32'(i0.underflow), 32'd1);
      chk("udf_hold",  32'(i0.data_out), 32'h10);

      // FWFT fall-through
      step(1, 0, 0, 8'hA5);
      chk("fwft_empty", 32'(i1.empty), 32'd0);
      chk("fwft_dout",  32'(i1.data_out), 32'hA5);
      step(0, 1, 0, 8'h00);

      // steady state at 8 with wrapping pointers
      fill_to(8);
      for (int k = 0; k < 40; k++) step(1, 1, 0, 8'($urandom));
      chk("steady_count", 32'(i0.count), 32'd8);

      // full with write+read
      fill_to(16);
      step(1, 1, 0, 8'h5A);
      chk("fullwr_count", 32'(i0.count), 32'd15);
      chk("fullwr_ovf",   32'(i0.overflow), 32'd1);

      // flush with write pending
      fill_to(5);
      step(1, 0, 1, 8'h77);
      chk("clr_count", 32'(i0.count), 32'd0);
      chk("clr_empty", 32'(i0.empty), 32'd1);
      chk("clr_ovf",   32'(i0.overflow), 32'd0);

      // async reset mid-burst
      fill_to(5);
      step(1, 1, 0, 8'h33);
      rst = 1'b0;
      model_reset();
      #1;
      chk("arst_count", 32'(i0.count), 32'd0);
      chk("arst_empty", 32'(i0.empty), 32'd1);
      chk("arst_ae",    32'(i0.almost_empty), 32'd1);
      chk("arst_dout",  32'(i0.data_out), 32'd0);
      step(1, 1, 0, 8'h44);
      step(1, 0, 0, 8'h45);
      rst = 1'b1;
      step(1, 0, 0, 8'h46);
      chk("post_rst_count", 32'(i0.count), 32'd1);

      // random traffic, alternating bias to reach both extremes
      for (int k = 0; k < 3000; k++) begin
         int p;
         p = ((k / 150) % 2 == 1) ? 75 : 25;
         step($urandom_range(99) < p, $urandom_range(99) < (100 - p),
              $urandom_range(63) == 0, 8'($urandom));
      end

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sync_fifo_ext.md
SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 Parameter: FIFO_WIDTH, 8, data width in bits (>=1).
REQ-002 Parameter: FIFO_DEPTH, 16, number of entries; power of 2, >=4.
REQ-003 Parameter: AF_LEVEL, FIFO_DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_LEVEL.
REQ-004 Parameter: AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL.
REQ-005 Parameter: FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 CLK  input  1  sole clock; all state changes on rising edge.
REQ-007 RST  input  1  asynchronous, active-low reset.
REQ-008 CLR  input  1  synchronous flush, active-high.
REQ-009 DATA_IN  input  FIFO_WIDTH  write data.
REQ-010 WR_EN  input  1  write request.
REQ-011 RD_EN  input  1  read request.
REQ-012 DATA_OUT  output  FIFO_WIDTH  read data.
REQ-013 EMPTY, FULL  output  1 each  occupancy flags.
REQ-014 ALMOST_EMPTY, ALMOST_FULL  output  1 each  threshold flags.
REQ-015 COUNT  output  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
REQ-016 OVERFLOW, UNDERFLOW  output  1 each  one-cycle error pulses.

Function
REQ-017 Write accepted iff WR_EN=1, FULL=0, CLR=0; DATA_IN stored at write pointer, pointer +1 mod FIFO_DEPTH.
REQ-018 Read accepted iff RD_EN=1, EMPTY=0, CLR=0; read pointer +1 mod FIFO_DEPTH.
REQ-019 Write while FULL=1 is rejected even if a read is accepted in the same cycle; contents unchanged.
REQ-020 Simultaneous accepted read and write: COUNT unchanged, both pointers advance.
REQ-021 COUNT, EMPTY, FULL, ALMOST_* are registered and reflect accepted operations from the previous edge; EMPTY = (COUNT==0), FULL = (COUNT==FIFO_DEPTH).
REQ-022 FWFT=0: DATA_OUT is a register loaded with the head entry on the edge of an accepted read (1-cycle latency); otherwise holds its value.
REQ-023 FWFT=1: DATA_OUT presents the head entry whenever EMPTY=0 (0-cycle latency); accepted read shows next entry after the edge; DATA_OUT don't-care while EMPTY=1.
REQ-024 FWFT=1: first write into empty FIFO makes EMPTY=0 and DATA_OUT valid on the following cycle.
REQ-025 OVERFLOW pulses high for one cycle after an edge where WR_EN=1 and the write was rejected due to FULL.
REQ-026 UNDERFLOW pulses high for one cycle after an edge where RD_EN=1 and EMPTY=1.
REQ-027 CLR=1 overrides WR_EN/RD_EN: pointers and COUNT to 0, flags to reset values on next edge; memory contents not cleared; no OVERFLOW/UNDERFLOW generated.
REQ-028 Pointers wrap from FIFO_DEPTH-1 to 0 with no gap or data loss.
REQ-029 Storage array is not reset.

Reset
REQ-030 RST=0 asynchronously forces: pointers 0, COUNT 0, EMPTY 1, ALMOST_EMPTY 1, FULL 0, ALMOST_FULL 0, OVERFLOW 0, UNDERFLOW 0, DATA_OUT 0.
REQ-031 Reset asserted mid-operation discards all stored data; no accepted operation on the edge coinciding with RST=0.
REQ-032 Reset release is synchronous to CLK; first operation accepted on first edge with RST=1.

Verification
REQ-033 Defaults, FWFT=0: 16 writes 0x01..0x10 -> FULL=1, COUNT=16, ALMOST_FULL=1 from COUNT=14; 17th write -> OVERFLOW one cycle, contents unchanged.
REQ-034 Drain 16 reads -> DATA_OUT 0x01..0x10 each one cycle after read; EMPTY=1 after last; extra read -> UNDERFLOW one cycle, DATA_OUT holds 0x10.
REQ-035 FWFT=1: write 0xA5 to empty FIFO -> next cycle EMPTY=0, DATA_OUT=0xA5 without RD_EN.
REQ-036 COUNT=8, simultaneous WR_EN/RD_EN for 40 cycles -> COUNT stays 8, pointers wrap, data order preserved.
REQ-037 FULL with WR_EN=1 and RD_EN=1 -> read accepted, write rejected, OVERFLOW pulse, COUNT=15.
REQ-038 COUNT=5, CLR=1 with WR_EN=1 -> COUNT=0, EMPTY=1, no OVERFLOW; repeat with RST=0 mid-burst -> all outputs to reset values immediately.
